dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/rr_picker.sv | 31 +++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default
// bus widths and the request-to-ack latencies seen by a core.
package dmem_arb_pkg;

  localparam int AW_DEFAULT = 16;
  localparam int DW_DEFAULT = 16;

  // Cycles from the request-sampling edge to the edge where the core sees ack
  localparam int WRITE_LATENCY = 3;
  localparam int READ_LATENCY  = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_ACCESS    = 2'd1;
  localparam state_t ST_READ_WAIT = 2'd2;
  localparam state_t ST_ACK       = 2'd3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester found searching upward
// from last_grant+1 with wrap-around; grant is one-hot, all-zero if no request.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last_grant) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving NUM_CORES cores serialised access to one
// single-port, synchronous-read data memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int AW        = AW_DEFAULT,
  parameter int DW        = DW_DEFAULT
) (
  input  logic                         clk,
  input  logic                         RESET_N,
  input  logic [NUM_CORES-1:0]         core_dread,
  input  logic [NUM_CORES-1:0]         core_dwrite,
  input  logic [NUM_CORES*AW-1:0]      core_addr,
  input  logic [NUM_CORES*DW-1:0]      core_wdata,
  output logic [NUM_CORES-1:0]         core_ack,
  output logic [DW-1:0]                core_rdata,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_wdata,
  output logic                         mem_read,
  output logic                         mem_write,
  input  logic [DW-1:0]                mem_rdata,
  output logic [$clog2(NUM_CORES)-1:0] grant_id,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_CORES);

  logic [NUM_CORES-1:0] core_req;
  logic [AW-1:0]        addr_arr  [NUM_CORES];
  logic [DW-1:0]        wdata_arr [NUM_CORES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign core_req[gi]  = core_dread[gi] | core_dwrite[gi];
      assign addr_arr[gi]  = core_addr[AW*gi +: AW];
      assign wdata_arr[gi] = core_wdata[DW*gi +: DW];
    end
  endgenerate

  state_t               state_reg, state_next;
  logic [IW-1:0]        last_grant_reg, last_grant_next;
  logic [NUM_CORES-1:0] win_reg, win_next;
  logic [AW-1:0]        addr_reg, addr_next;
  logic [DW-1:0]        wdata_reg, wdata_next;
  logic                 op_write_reg, op_write_next;
  logic [NUM_CORES-1:0] ack_reg, ack_next;
  logic [DW-1:0]        rdata_reg, rdata_next;

  // A core still holds its request during the cycle it sees ack; mask it out
  logic [NUM_CORES-1:0] req_masked;
  logic [NUM_CORES-1:0] pick_grant;
  logic [IW-1:0]        pick_idx;

  assign req_masked = core_req & ~ack_reg;

  rr_picker #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_rr_picker (
    .req        (req_masked),
    .last_grant (last_grant_reg),
    .grant      (pick_grant),
    .idx        (pick_idx)
  );

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    win_next        = win_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    op_write_next   = op_write_reg;
    ack_next        = '0;
    rdata_next      = rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|pick_grant) begin
          last_grant_next = pick_idx;
          win_next        = pick_grant;
          addr_next       = addr_arr[pick_idx];
          wdata_next      = wdata_arr[pick_idx];
          // Write wins when a core raises both dread and dwrite
          op_write_next   = core_dwrite[pick_idx];
          state_next      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = op_write_reg ? ST_ACK : ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        rdata_next = mem_rdata;
        state_next = ST_ACK;
      end
      ST_ACK: begin
        ack_next   = win_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= IW'(NUM_CORES - 1);
      win_reg        <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      op_write_reg   <= 1'b0;
      ack_reg        <= '0;
      rdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      win_reg        <= win_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      op_write_reg   <= op_write_next;
      ack_reg        <= ack_next;
      rdata_reg      <= rdata_next;
    end
  end

  assign core_ack   = ack_reg;
  assign core_rdata = rdata_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_read   = (state_reg == ST_ACCESS) && !op_write_reg;
  assign mem_write  = (state_reg == ST_ACCESS) && op_write_reg;
  assign grant_id   = last_grant_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for latency, grant order and reset.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            RESET_N = 1'b0;
  logic [NC-1:0]   core_dread = '0;
  logic [NC-1:0]   core_dwrite = '0;
  logic [NC*AW-1:0] core_addr = '0;
  logic [NC*DW-1:0] core_wdata = '0;
  logic [NC-1:0]   core_ack;
  logic [DW-1:0]   core_rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_read;
  logic            mem_write;
  logic [DW-1:0]   mem_rdata;
  logic [1:0]      grant_id;
  logic            busy;

  dmem_arbiter #(.NUM_CORES(NC), .AW(AW), .DW(DW)) dut (
    .clk(clk), .RESET_N(RESET_N),
    .core_dread(core_dread), .core_dwrite(core_dwrite),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous-read memory attached to the arbiter
  logic [DW-1:0] phys [0:255];
  always @(posedge clk) begin
    if (mem_read)  mem_rdata <= phys[mem_addr[7:0]];
    if (mem_write) phys[mem_addr[7:0]] <= mem_wdata;
  end

  // ---------------- transaction-level reference model ----------------
  logic          model_live = 1'b0;
  logic          m_active = 1'b0;
  int            m_phase = 0;     // cycles since the grant edge
  int            m_core = 0;
  int            m_last = NC - 1;
  int            m_best = -1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_wr = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [NC-1:0] m_ack = '0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  always @(posedge clk) begin
    if (!RESET_N) begin
      model_live = 1'b1;
      m_active   = 1'b0;
      m_phase    = 0;
      m_last     = NC - 1;
      m_rdata    = '0;
      m_ack      = '0;
    end else if (m_active) begin
      m_phase = m_phase + 1;
      if (m_phase == 2 && m_wr) ref_mem[m_addr] = m_data;
      if (m_phase == 3 && !m_wr) m_rdata = ref_mem.exists(m_addr) ? ref_mem[m_addr] : '0;
      if (m_phase == (m_wr ? WRITE_LATENCY : READ_LATENCY)) begin
        m_active = 1'b0;
        m_ack    = NC'(1) << m_core;
      end
    end else begin
      // Nearest requester after the last grant; the core being acked is still holding
      m_best = -1;
      for (int k = 0; k < NC; k++) begin
        if ((core_dread[k] || core_dwrite[k]) && !m_ack[k]) begin
          if (m_best < 0 || ((k - m_last - 1 + NC) % NC) < ((m_best - m_last - 1 + NC) % NC))
            m_best = k;
        end
      end
      m_ack = '0;
      if (m_best >= 0) begin
        m_active = 1'b1;
        m_phase  = 1;
        m_core   = m_best;
        m_last   = m_best;
        m_addr   = core_addr[m_best*AW +: AW];
        m_data   = core_wdata[m_best*DW +: DW];
        m_wr     = core_dwrite[m_best];
      end
    end
  end

  // ---------------- checking and stimulus ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_q [$];
  int n_wr_pulse = 0;
  int n_rd_pulse = 0;
  logic [NC-1:0] ack_seen;
  logic [DW-1:0] rd_seen;
  logic [DW-1:0] last_ack_rdata;
  logic          busy_seen;
  logic [1:0]    grant_seen;
  logic [AW-1:0] addr_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_outputs();
    check("busy", busy, m_active);
    check("mem_read", mem_read, m_active && m_phase == 1 && !m_wr);
    check("mem_write", mem_write, m_active && m_phase == 1 && m_wr);
    check("core_ack", core_ack, m_ack);
    check("core_rdata", core_rdata, m_rdata);
    check("grant_id", grant_id, m_last);
    if (m_active && m_phase == 1) check("mem_addr", mem_addr, m_addr);
    if (m_active && m_phase == 1 && m_wr) check("mem_wdata", mem_wdata, m_data);
  endtask

  // One clock: compare at the falling edge, then let acked cores drop requests
  task automatic tick();
    @(negedge clk);
    ack_seen   = core_ack;
    rd_seen    = core_rdata;
    busy_seen  = busy;
    grant_seen = grant_id;
    addr_seen  = mem_addr;
    if (model_live) compare_outputs();
    if (mem_write) n_wr_pulse++;
    if (mem_read)  n_rd_pulse++;
    for (int k = 0; k < NC; k++) begin
      if (ack_seen[k]) begin
        ack_q.push_back(k);
        last_ack_rdata = core_rdata;
        $display("txn %0d: core %0d acked, rdata=%04h, cycle %0d", ack_q.size(), k, core_rdata, cyc);
      end
    end
    @(posedge clk);
    #1;
    core_dread  = core_dread & ~ack_seen;
    core_dwrite = core_dwrite & ~ack_seen;
    cyc++;
  endtask

  task automatic set_req(input int k, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_dread[k]           = rd;
    core_dwrite[k]          = wr;
    core_addr[k*AW +: AW]   = a;
    core_wdata[k*DW +: DW]  = d;
  endtask

  // Issue one request and measure edges from the request edge to the ack edge
  task automatic single(input int k, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output logic [NC-1:0] ack);
    int n;
    n   = 0;
    lat = -1;
    ack = '0;
    n_wr_pulse = 0;
    n_rd_pulse = 0;
    set_req(k, rd, wr, a, d);
    while (n < 20 && lat < 0) begin
      tick();
      n++;
      if (ack_seen != 0) begin
        lat = n - 1;
        ack = ack_seen;
      end
    end
    check("single_completed", lat >= 0, 1);
  endtask

  task automatic run_acks(input int n);
    int start;
    int t;
    start = ack_q.size();
    t = 0;
    while (t < 60 && ack_q.size() < start + n) begin
      tick();
      t++;
    end
    check("acks_within_budget", ack_q.size() >= start + n, 1);
  endtask

  initial begin
    int lat;
    int base;
    logic [NC-1:0] ack;

    // Reset state
    tick();
    tick();
    check("reset_rdata", rd_seen, 16'h0000);
    check("reset_busy", busy_seen, 0);
    check("reset_grant_id", grant_seen, 3);
    check("reset_ack", ack_seen, 0);
    check("reset_mem_addr", addr_seen, 16'h0000);
    RESET_N = 1'b1;
    tick();

    // Single write by core 2
    single(2, 1'b0, 1'b1, 16'h0010, 16'hABCD, lat, ack);
    check("write_latency", lat, 3);
    check("write_ack", ack, 4'b0100);
    check("write_pulses", n_wr_pulse, 1);
    tick();

    // Single read by core 1
    single(1, 1'b1, 1'b0, 16'h0010, 16'h0000, lat, ack);
    check("read_latency", lat, 4);
    check("read_ack", ack, 4'b0010);
    check("read_rdata", last_ack_rdata, 16'hABCD);
    check("read_pulses", n_rd_pulse, 1);
    tick();

    // dread and dwrite together: treated as a write, rdata untouched
    single(0, 1'b1, 1'b1, 16'h0001, 16'h1234, lat, ack);
    check("rw_latency", lat, 3);
    check("rw_ack", ack, 4'b0001);
    check("rw_rdata_held", last_ack_rdata, 16'hABCD);
    check("rw_no_read", n_rd_pulse, 0);
    check("rw_write", n_wr_pulse, 1);
    single(3, 1'b1, 1'b0, 16'h0001, 16'h0000, lat, ack);
    check("rw_readback", last_ack_rdata, 16'h1234);
    tick();

    // Reset while the read sits in READ_WAIT
    base = ack_q.size();
    set_req(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();
    tick();
    RESET_N     = 1'b0;
    core_dread  = '0;
    core_dwrite = '0;
    tick();
    RESET_N = 1'b1;
    tick();
    check("midreset_busy", busy_seen, 0);
    check("midreset_rdata", rd_seen, 16'h0000);
    check("midreset_no_ack", ack_q.size(), base);
    tick();

    // Contention from reset: all four write, then all four read back
    base = ack_q.size();
    for (int k = 0; k < NC; k++) set_req(k, 1'b0, 1'b1, AW'(16'h0020 + k), DW'(16'h1000 + k));
    run_acks(4);
    for (int k = 0; k < NC; k++) set_req(k, 1'b1, 1'b0, AW'(16'h0020 + k), 16'h0000);
    run_acks(4);
    for (int i = 0; i < 8; i++) check("rr_order", ack_q[base + i], i % NC);
    check("contention_last_rdata", last_ack_rdata, 16'h1003);
    tick();

    // Wrap-around: last grant is 3, cores 0 and 3 request
    base = ack_q.size();
    set_req(3, 1'b0, 1'b1, 16'h0030, 16'h5555);
    set_req(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    run_acks(1);
    check("wrap_winner", ack_q[base], 0);
    check("wrap_rdata", last_ack_rdata, 16'h1000);
    run_acks(1);
    check("wrap_second", ack_q[base + 1], 3);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
